load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit -- single-outstanding byte/half/word load/store unit that
// uses read-modify-write for sub-word stores.           Rev 1.0
// ============================================================================
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rword_q, rword_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;

  logic        misaligned;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] store_word;

  always_comb begin
    misaligned = (req_size == 2'b11)
               | ((req_size == 2'b01) & req_addr[0])
               | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rword_d = rword_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          err_d   = misaligned;
          rword_d = '0;
          if (misaligned)
            state_d = RESP;
          else if (req_we && (req_size == 2'b10))
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ: begin
        rword_d = mem_rdata;
        state_d = we_q ? WRITE : RESP;
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_byte = rword_q[7:0];
      2'd1:    lane_byte = rword_q[15:8];
      2'd2:    lane_byte = rword_q[23:16];
      default: lane_byte = rword_q[31:24];
    endcase
    lane_half = addr_q[1] ? rword_q[31:16] : rword_q[15:0];
    case (size_q)
      2'b00:   load_val = uns_q ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_val = uns_q ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_val = rword_q;
    endcase
  end

  // Sub-word stores merge into the word fetched during READ.
  always_comb begin
    store_word = rword_q;
    case (size_q)
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    store_word[7:0]   = wdata_q[7:0];
          2'd1:    store_word[15:8]  = wdata_q[7:0];
          2'd2:    store_word[23:16] = wdata_q[7:0];
          default: store_word[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1])
          store_word[31:16] = wdata_q[15:0];
        else
          store_word[15:0]  = wdata_q[15:0];
      end
      default: store_word = wdata_q;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE) & rst_n;
    rsp_valid = (state_q == RESP);
    rsp_err   = (state_q == RESP) & err_q;
    rsp_rdata = ((state_q == RESP) && !err_q && !we_q) ? load_val : 32'd0;
    mem_addr  = ((state_q == READ) || (state_q == WRITE)) ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_we    = (state_q == WRITE);
    mem_wdata = (state_q == WRITE) ? store_word : 32'd0;
  end

  // Async clear takes state out of WRITE at once, so mem_we falls with rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rword_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rword_q <= rword_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit -- scoreboard bench: directed and random requests checked
// against a byte-level memory reference model.          Rev 1.0
// ============================================================================
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  load_store_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  rsp_t        rsp_q[$];
  wr_t         wr_q[$];
  rsp_t        mr;
  wr_t         mw;
  logic [31:0] tb_mem  [0:63];
  logic [31:0] ref_mem [0:63];
  bit          load_mem;
  int          cyc;
  int          acc_cnt;
  int          abort_cnt;
  int          rsp_cnt;
  int          n_cmp;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = tb_mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= ref_mem[i];
    end else if (mem_we) begin
      tb_mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: memory viewed as bytes, requests resolved with shifts and masks.
  task automatic model(input bit we, input bit [1:0] size, input bit uns,
                       input bit [31:0] addr, input bit [31:0] wdata, input int acc);
    rsp_t    r;
    wr_t     w;
    bit [63:0] mask;
    bit [63:0] word;
    bit [63:0] val;
    int      sh;
    int      nbits;
    r.acc   = acc;
    r.rdata = 32'd0;
    r.err   = 1'b0;
    r.lat   = 1;
    if (size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)) begin
      r.err = 1'b1;
    end else begin
      nbits = 8 << size;
      sh    = 8 * int'(addr[1:0]);
      mask  = (64'd1 << nbits) - 64'd1;
      word  = {32'd0, ref_mem[addr[7:2]]};
      if (!we) begin
        val = (word >> sh) & mask;
        if (!uns && nbits < 32 && val[nbits-1]) val = val | ~mask;
        r.rdata = val[31:0];
        r.lat   = 2;
      end else begin
        word = (word & ~(mask << sh)) | (({32'd0, wdata} & mask) << sh);
        ref_mem[addr[7:2]] = word[31:0];
        w.addr = {addr[31:2], 2'b00};
        w.data = word[31:0];
        wr_q.push_back(w);
        r.lat = (nbits == 32) ? 2 : 3;
      end
    end
    rsp_q.push_back(r);
  endtask

  task automatic issue(input bit we, input bit [1:0] size, input bit uns, input bit [31:0] addr,
                       input bit [31:0] wdata, input bit hold, input bit expect_rsp);
    int waited = 0;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      if (expect_rsp) model(we, size, uns, addr, wdata, cyc);
      @(posedge clk);
      #1;
      acc_cnt++;
      if (!hold) req_valid = 1'b0;
    end
  endtask

  // Monitor: owns all response/memory-port checking.
  always @(negedge clk) begin
    if (rst_n && !load_mem) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, acc_cnt == rsp_cnt + abort_cnt});
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_mem_we", 32'd1, 32'd0);
        end else begin
          mw = wr_q.pop_front();
          chk("mem_addr", mem_addr, mw.addr);
          chk("mem_wdata", mem_wdata, mw.data);
        end
      end else if (acc_cnt == rsp_cnt + abort_cnt) begin
        chk("idle_mem_addr", mem_addr, 32'd0);
        chk("idle_mem_wdata", mem_wdata, 32'd0);
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          mr = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, mr.rdata);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, mr.err});
          chk("rsp_latency", cyc - mr.acc, mr.lat);
        end
        rsp_cnt++;
      end
    end
  end

  initial begin
    int wait_cyc;
    bit [1:0] rs;
    cyc = 0; acc_cnt = 0; abort_cnt = 0; rsp_cnt = 0; n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    ref_mem[4] = 32'h8899AABB;
    load_mem = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    end
    load_mem = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;

    issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0, 1'b1);         // LB signed
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0, 1'b1);         // LHU
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1);         // LW
    issue(1'b1, 2'd2, 1'b0, 32'h22, 32'hDEADBEEF, 1'b0, 1'b1);  // misaligned SW

    // SH aborted by reset while in READ.
    issue(1'b1, 2'd1, 1'b0, 32'h10, 32'h00001234, 1'b0, 1'b0);
    rst_n = 1'b0;
    abort_cnt++;
    #1;
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_word_kept", tb_mem[4], 32'h8899AABB);
    @(posedge clk); #1;

    issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h00000055, 1'b0, 1'b1);  // SB
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1);         // LW after SB
    repeat (2) @(posedge clk);
    chk("sb_word", tb_mem[4], 32'h5599AABB);
    #1;

    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1);         // back-to-back LW
    issue(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1);

    for (int n = 0; n < 200; n++) begin
      rs = 2'($urandom_range(0, 3));
      issue(1'($urandom), rs, 1'($urandom), 32'($urandom_range(0, 255)), $urandom,
            ($urandom_range(0, 3) == 0), 1'b1);
      if ($urandom_range(0, 4) == 0) begin
        req_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;

    wait_cyc = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    repeat (2) @(posedge clk);
    chk("rsp_queue_drained", rsp_q.size(), 32'd0);
    chk("wr_queue_drained", wr_q.size(), 32'd0);
    for (int i = 0; i < 64; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
